// File: rtl/truth_table_scanner.sv
// Walks a 3-input gate through all eight input vectors, captures its truth table
// and reports the population count and a comparison against a reference table.
module truth_table_scanner #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [7:0]  EXPECTED = 8'h54
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       F,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_o,
    output logic [3:0] ones_count,
    output logic       match
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [2:0] index_q, index_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] table_q, table_d;
    logic [3:0] ones_q, ones_d;
    logic       match_q, match_d;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (settle_q <= 4'd1) state_d = SAMPLE;
            SAMPLE:  state_d = (index_q == 3'd7) ? DONE : DRIVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        {A, B, C} = 3'b000;
        case (state_q)
            DRIVE, SAMPLE: begin
                busy = 1'b1;
                {A, B, C} = index_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: index/settle sequencing, table capture and result summary.
    always_comb begin
        index_d  = index_q;
        settle_d = settle_q;
        table_d  = table_q;
        ones_d   = ones_q;
        match_d  = match_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    index_d  = 3'd0;
                    settle_d = SETTLE_L;
                    table_d  = 8'h00;
                    ones_d   = 4'd0;
                    match_d  = 1'b0;
                end
            end
            DRIVE: settle_d = settle_q - 4'd1;
            SAMPLE: begin
                table_d[index_q] = F;
                if (index_q == 3'd7) begin
                    ones_d  = popcount8(table_d);
                    match_d = (table_d == EXPECTED);
                end else begin
                    index_d  = index_q + 3'd1;
                    settle_d = SETTLE_L;
                end
            end
            DONE:    index_d = 3'd0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q  <= 3'd0;
            settle_q <= 4'd0;
            table_q  <= 8'h00;
            ones_q   <= 4'd0;
            match_q  <= 1'b0;
        end else begin
            index_q  <= index_d;
            settle_q <= settle_d;
            table_q  <= table_d;
            ones_q   <= ones_d;
            match_q  <= match_d;
        end
    end

    assign table_o    = table_q;
    assign ones_count = ones_q;
    assign match      = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: one instance with SETTLE=1 driven by a
// gate model, one with SETTLE=3 whose F is disturbed outside the sample cycle.
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start3;
    logic       F1, F3;
    logic       A1, B1, C1, busy1, done1, match1;
    logic       A3, B3, C3, busy3, done3, match3;
    logic [7:0] tbl1, tbl3;
    logic [3:0] ones1, ones3;
    int         f_mode;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    truth_table_scanner #(.SETTLE(1), .EXPECTED(8'h54)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .F(F1),
        .A(A1), .B(B1), .C(C1), .busy(busy1), .done(done1),
        .table_o(tbl1), .ones_count(ones1), .match(match1)
    );

    truth_table_scanner #(.SETTLE(3), .EXPECTED(8'h54)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .F(F3),
        .A(A3), .B(B3), .C(C3), .busy(busy3), .done(done3),
        .table_o(tbl3), .ones_count(ones3), .match(match3)
    );

    // Gate under test: 1 only for vectors 2, 4 and 6
    function automatic logic gate(input logic [2:0] v);
        return (v == 3'd2) || (v == 3'd4) || (v == 3'd6);
    endfunction

    always_comb begin
        case (f_mode)
            1:       F1 = 1'b0;
            2:       F1 = 1'b1;
            default: F1 = gate({A1, B1, C1});
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, "_abc"},   {5'b0, A1, B1, C1}, 8'h00);
        chk({tag, "_busy"},  {7'b0, busy1}, 8'h00);
        chk({tag, "_done"},  {7'b0, done1}, 8'h00);
        chk({tag, "_table"}, tbl1, 8'h00);
        chk({tag, "_ones"},  {4'b0, ones1}, 8'h00);
        chk({tag, "_match"}, {7'b0, match1}, 8'h00);
    endtask

    // One SETTLE=1 scan; cycle 0 is the accepting edge, done expected in cycle 17
    task automatic scan1(input logic [7:0] exp_tbl, input logic [3:0] exp_ones,
                         input logic exp_match, input bit pulse_mid);
        logic [7:0] mask;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            start1 = pulse_mid && (cyc == 5 || cyc == 10);
            if (cyc < 17) begin
                mask = 8'((9'd1 << ((cyc - 1) / 2)) - 9'd1);
                chk($sformatf("vec_c%0d", cyc), {5'b0, A1, B1, C1}, 8'((cyc - 1) / 2));
                chk($sformatf("busy_c%0d", cyc), {7'b0, busy1}, 8'h01);
                chk($sformatf("done_c%0d", cyc), {7'b0, done1}, 8'h00);
                chk($sformatf("partial_c%0d", cyc), tbl1, exp_tbl & mask);
            end else begin
                chk("done_c17", {7'b0, done1}, 8'h01);
                chk("busy_c17", {7'b0, busy1}, 8'h00);
                chk("abc_c17", {5'b0, A1, B1, C1}, 8'h00);
                chk("table_c17", tbl1, exp_tbl);
                chk("ones_c17", {4'b0, ones1}, {4'b0, exp_ones});
                chk("match_c17", {7'b0, match1}, {7'b0, exp_match});
            end
        end
        @(negedge clk);
        chk("done_c18", {7'b0, done1}, 8'h00);
        chk("busy_c18", {7'b0, busy1}, 8'h00);
        chk("table_hold", tbl1, exp_tbl);
        chk("ones_hold", {4'b0, ones1}, {4'b0, exp_ones});
        chk("match_hold", {7'b0, match1}, {7'b0, exp_match});
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        F3     = 1'b0;
        f_mode = 0;
        #1;
        chk_zero1("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reference gate
        scan1(8'h54, 4'd3, 1'b1, 1'b0);

        // Constant F
        f_mode = 1;
        scan1(8'h00, 4'd0, 1'b0, 1'b0);
        f_mode = 2;
        scan1(8'hFF, 4'd8, 1'b0, 1'b0);
        f_mode = 0;

        // Start pulses mid-scan are ignored, no second scan follows
        scan1(8'h54, 4'd3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("noqueue_busy%0d", i), {7'b0, busy1}, 8'h00);
            chk($sformatf("noqueue_done%0d", i), {7'b0, done1}, 8'h00);
        end

        // Start held high: back-to-back scans, done in cycles 17 and 35
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 35; cyc++) begin
            @(negedge clk);
            if (cyc == 35) start1 = 1'b0;
            chk($sformatf("hold_done_c%0d", cyc), {7'b0, done1},
                {7'b0, (cyc == 17 || cyc == 35)});
            chk($sformatf("hold_busy_c%0d", cyc), {7'b0, busy1},
                {7'b0, !(cyc == 17 || cyc == 18 || cyc == 35)});
        end
        chk("hold_table", tbl1, 8'h54);
        @(negedge clk);
        chk("hold_idle_busy", {7'b0, busy1}, 8'h00);

        // Reset while vector 4 is applied
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
        end
        chk("abort_vec4", {5'b0, A1, B1, C1}, 8'h04);
        rst = 1'b1;
        #1;
        chk_zero1("abort");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("abort_done%0d", i), {7'b0, done1}, 8'h00);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post_abort_done%0d", i), {7'b0, done1}, 8'h00);
        end
        scan1(8'h54, 4'd3, 1'b1, 1'b0);

        // SETTLE=3: F disturbed during DRIVE, gate value only in SAMPLE
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 33; cyc++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (cyc < 33) begin
                chk($sformatf("s3_vec_c%0d", cyc), {5'b0, A3, B3, C3}, 8'((cyc - 1) / 4));
                chk($sformatf("s3_done_c%0d", cyc), {7'b0, done3}, 8'h00);
                case ((cyc - 1) % 4)
                    3:       F3 = gate(3'((cyc - 1) / 4));
                    2:       F3 = !gate(3'((cyc - 1) / 4));
                    default: F3 = 1'($urandom_range(0, 1));
                endcase
            end else begin
                chk("s3_done_c33", {7'b0, done3}, 8'h01);
                chk("s3_busy_c33", {7'b0, busy3}, 8'h00);
                chk("s3_table", tbl3, 8'h54);
                chk("s3_ones", {4'b0, ones3}, 8'h03);
                chk("s3_match", {7'b0, match3}, 8'h01);
            end
        end
        @(negedge clk);
        chk("s3_idle_done", {7'b0, done3}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
